// File: rtl/imem.sv
// rtl/imem.sv - loadable word-addressed instruction memory with a latency-configurable fetch pipeline
// Fetches return mem[addr>>2] after LATENCY stages; misaligned or out-of-range fetches return 0 with err set.
module imem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [DATA_W-1:0]  dat_q [LATENCY];

    logic              advance;
    logic              req_legal;
    logic              ld_legal;
    logic [MEM_AW-1:0] req_idx;
    logic [MEM_AW-1:0] ld_idx;
    logic [DATA_W-1:0] s0_dat_d;
    logic              s0_err_d;

    // Index is compared zero-extended so DEPTH == 2^(ADDR_W-2) still fits the comparison.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[ADDR_W-1:2]} < DEPTH_A);
    endfunction

    always_comb begin
        advance   = !(rsp_valid && !rsp_ready);
        req_ready = advance;
        req_legal = addr_legal(req_addr);
        ld_legal  = addr_legal(ld_addr);
        req_idx   = req_addr[MEM_AW+1:2];
        ld_idx    = ld_addr[MEM_AW+1:2];
        s0_dat_d  = '0;
        s0_err_d  = 1'b0;
        if (req_valid) begin
            if (req_legal) begin
                s0_dat_d = mem_q[req_idx];
            end else begin
                s0_err_d = 1'b1;
            end
        end
    end

    // The array is read combinationally above, so a same-edge load is seen only by later fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ld_en && ld_legal) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= req_valid;
            dat_q[0] <= s0_dat_d;
            err_q[0] <= s0_err_d;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    assign rsp_valid = vld_q[LATENCY-1];
    assign rsp_data  = dat_q[LATENCY-1];
    assign rsp_err   = err_q[LATENCY-1];

endmodule

// File: tb/tb_imem.sv
// tb/tb_imem.sv - scoreboard bench driving three imem instances (LATENCY 1, 2, 3) with shared stimulus
module tb_imem;
    localparam int NDUT = 3;
    localparam int SB   = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    logic [NDUT-1:0] req_ready_w;
    logic [NDUT-1:0] rsp_valid_w;
    logic [NDUT-1:0] rsp_err_w;
    logic [31:0]     rsp_data_w [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        imem #(
            .DATA_W (32),
            .ADDR_W (32),
            .DEPTH  (16),
            .LATENCY(g + 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid),
            .req_ready(req_ready_w[g]),
            .req_addr (req_addr),
            .rsp_valid(rsp_valid_w[g]),
            .rsp_ready(rsp_ready),
            .rsp_data (rsp_data_w[g]),
            .rsp_err  (rsp_err_w[g]),
            .ld_en    (ld_en),
            .ld_addr  (ld_addr),
            .ld_data  (ld_data)
        );
    end

    logic [31:0] sb_data [NDUT][SB];
    logic        sb_err  [NDUT][SB];
    int          sb_cyc  [NDUT][SB];
    int          sb_stl  [NDUT][SB];
    int          sb_tail [NDUT];
    int          sb_head [NDUT];
    int          stall_cnt [NDUT];
    logic [31:0] ref_mem [16];
    int          cyc_cnt;
    int          m_slot;
    int          c_slot;

    int          n_cmp;
    int          n_fail;
    bit          prev_stall [NDUT];
    logic [31:0] prev_data  [NDUT];
    logic        prev_err   [NDUT];
    bit          finish_req;
    bit          timeout_flag;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < 16);
    endfunction

    // Reference model: memory contents as seen at each acceptance edge, sampled before that edge's load.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            foreach (ref_mem[i]) ref_mem[i] = '0;
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (req_valid && req_ready_w[k]) begin
                    m_slot = sb_tail[k] % SB;
                    sb_data[k][m_slot] = legal(req_addr) ? ref_mem[req_addr[5:2]] : 32'h0;
                    sb_err[k][m_slot]  = !legal(req_addr);
                    sb_cyc[k][m_slot]  = cyc_cnt;
                    sb_stl[k][m_slot]  = stall_cnt[k];
                    sb_tail[k]++;
                end
            end
            if (ld_en && legal(ld_addr)) ref_mem[ld_addr[5:2]] = ld_data;
        end
    end

    task automatic chk(input bit ok, input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s lat%0d: got %h, required %h at %0t", name, k + 1, act, exp, $time);
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            for (int k = 0; k < NDUT; k++) begin
                chk(rsp_valid_w[k] === 1'b0, "reset_rsp_valid", k, 32'(rsp_valid_w[k]), 32'h0);
                chk(req_ready_w[k] === 1'b1, "reset_req_ready", k, 32'(req_ready_w[k]), 32'h1);
                chk(rsp_data_w[k] === 32'h0, "reset_rsp_data", k, rsp_data_w[k], 32'h0);
                chk(rsp_err_w[k] === 1'b0, "reset_rsp_err", k, 32'(rsp_err_w[k]), 32'h0);
                sb_head[k]    = sb_tail[k];
                prev_stall[k] = 1'b0;
            end
        end else if (finish_req) begin
            for (int k = 0; k < NDUT; k++) begin
                chk(sb_head[k] == sb_tail[k], "drain_outstanding", k, 32'(sb_tail[k] - sb_head[k]), 32'h0);
            end
            chk(!timeout_flag, "drain_timeout", 0, 32'(timeout_flag), 32'h0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (prev_stall[k]) begin
                    chk(rsp_valid_w[k] === 1'b1, "stall_hold_valid", k, 32'(rsp_valid_w[k]), 32'h1);
                    chk(rsp_data_w[k] === prev_data[k], "stall_hold_data", k, rsp_data_w[k], prev_data[k]);
                    chk(rsp_err_w[k] === prev_err[k], "stall_hold_err", k, 32'(rsp_err_w[k]), 32'(prev_err[k]));
                end
                chk(req_ready_w[k] === !(rsp_valid_w[k] && !rsp_ready), "req_ready", k,
                    32'(req_ready_w[k]), 32'(!(rsp_valid_w[k] && !rsp_ready)));
                if (rsp_valid_w[k] && rsp_ready) begin
                    if (sb_head[k] == sb_tail[k]) begin
                        chk(1'b0, "unexpected_rsp", k, rsp_data_w[k], 32'h0);
                    end else begin
                        c_slot = sb_head[k] % SB;
                        chk(rsp_data_w[k] === sb_data[k][c_slot], "rsp_data", k, rsp_data_w[k], sb_data[k][c_slot]);
                        chk(rsp_err_w[k] === sb_err[k][c_slot], "rsp_err", k, 32'(rsp_err_w[k]), 32'(sb_err[k][c_slot]));
                        if (sb_stl[k][c_slot] == stall_cnt[k]) begin
                            chk(cyc_cnt - sb_cyc[k][c_slot] == k + 1, "latency", k,
                                32'(cyc_cnt - sb_cyc[k][c_slot]), 32'(k + 1));
                        end
                        sb_head[k]++;
                    end
                end
                prev_stall[k] = rsp_valid_w[k] && !rsp_ready;
                prev_data[k]  = rsp_data_w[k];
                prev_err[k]   = rsp_err_w[k];
                if (prev_stall[k]) stall_cnt[k]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        step();
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            if (sb_head[k] != sb_tail[k] || rsp_valid_w[k]) e = 1'b0;
        end
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = 32'h0;
        rsp_ready    = 1'b1;
        ld_en        = 1'b0;
        ld_addr      = 32'h0;
        ld_data      = 32'h0;
        finish_req   = 1'b0;
        timeout_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        fetch(32'h0); fetch(32'h4); fetch(32'h3C);
        idle(4);

        load(32'h00, 32'h00000000);
        load(32'h04, 32'h20080006);
        load(32'h08, 32'h2009000D);
        load(32'h0C, 32'h01095020);
        load(32'h10, 32'h010A4020);
        for (int a = 0; a <= 16; a += 4) fetch(32'(a));
        idle(4);

        fetch(32'h0); fetch(32'h4);
        rsp_ready = 1'b0;
        fetch(32'h8); fetch(32'hC); fetch(32'h10);
        rsp_ready = 1'b1;
        fetch(32'h4);
        idle(5);

        fetch(32'h6); fetch(32'h40);
        idle(1);
        load(32'h40, 32'hFFFFFFFF);
        for (int a = 0; a < 64; a += 4) fetch(32'(a));
        idle(4);

        ld_en = 1'b1; ld_addr = 32'hC; ld_data = 32'hDEADBEEF;
        fetch(32'hC);
        ld_en = 1'b0;
        fetch(32'hC);
        idle(4);

        fetch(32'h10); fetch(32'h0);
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        fetch(32'h4);
        idle(4);

        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       req_addr = $urandom;
                1:       req_addr = 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
                2:       req_addr = 4 * $urandom_range(16, 20);
                default: req_addr = 4 * $urandom_range(0, 15);
            endcase
            rsp_ready = ($urandom_range(0, 3) != 0);
            ld_en     = ($urandom_range(0, 4) == 0);
            ld_addr   = 4 * $urandom_range(0, 17) + (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0);
            ld_data   = $urandom;
            step();
        end

        req_valid = 1'b0;
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        for (int w = 0; w < 100 && !all_empty(); w++) step();
        if (!all_empty()) timeout_flag = 1'b1;
        finish_req = 1'b1;
    end

endmodule

// File: doc/imem.md
# imem

Parametrised, loadable instruction memory for the MIPS core. It replaces the fixed combinational instruction ROM with a word-addressed array that software or a bench loads through a write port. Fetches go through a valid/ready request/response pipeline with a configurable read latency, and misaligned or out-of-range fetches are flagged. It sits between the fetch stage and the program loader.

## Interface
Parameters:
- DATA_W, default 32: instruction word width in bits.
- ADDR_W, default 32: byte-address width of the fetch and load ports.
- DEPTH, default 16: number of words; legal range 1..2^(ADDR_W-2).
- LATENCY, default 1: read pipeline stages; legal range 1..3.

Ports:
- clk, input, 1: single clock; everything is rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: fetch request present.
- req_ready, output, 1: fetch request accepted this cycle when high together with req_valid.
- req_addr, input, ADDR_W: fetch byte address.
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_data, output, DATA_W: instruction word; 0 (nop) on error.
- rsp_err, output, 1: the fetch address was misaligned or out of range.
- ld_en, input, 1: write strobe for the load port.
- ld_addr, input, ADDR_W: load byte address.
- ld_data, input, DATA_W: load data.

## Operation
- Word index is addr[ADDR_W-1:2].
  - An address is legal when addr[1:0]==0 and index < DEPTH.
- Memory array:
  - DEPTH words.
  - Cleared to 0 asynchronously by reset.
- Load port:
  - On a clock edge with ld_en=1 and a legal ld_addr, the word at that index is written with ld_data.
  - An illegal ld_addr is ignored and no word changes.
- Fetch pipeline:
  - LATENCY stages, each holding a valid bit, data and error.
  - advance = !(rsp_valid && !rsp_ready).
  - req_ready = advance (combinational).
  - On an edge where advance=1, every stage shifts forward one position.
  - Stage 0 loads valid = req_valid, plus the read result for req_addr.
  - Illegal address: data = 0, err = 1. Legal address: data = mem[index], err = 0.
  - The last stage drives rsp_valid, rsp_data and rsp_err.
  - While advance=0, all stages hold their contents and no request is accepted.
  - Bubbles (stages with valid=0) are not compressed when advance=0.
  - Bubbles are overwritten as the pipeline advances.
- Read-before-write:
  - The array is sampled on the acceptance edge.
  - If a load and a fetch hit the same index on the same edge, the fetch returns the old word. The new word is visible to fetches accepted on later edges.
- A response is consumed on any edge where rsp_valid && rsp_ready.
- Reset mid-operation:
  - All stage valid bits clear immediately (asynchronously).
  - All in-flight fetches are discarded.
  - The array clears.

## Timing
- Reset values:
  - req_ready = 1.
  - rsp_valid = 0.
  - rsp_data = 0.
  - rsp_err = 0.
- Latency: a request accepted on edge N gives rsp_valid=1 after edge N+LATENCY-1, i.e. in the cycle following edge N+LATENCY-1. This holds when no backpressure occurs.
- Throughput: one fetch per cycle while rsp_ready=1.
- Backpressure: with rsp_valid=1 and rsp_ready=0, req_ready=0 in the same cycle, and rsp_data/rsp_err stay stable until consumed.
- Load write takes effect on the edge at which ld_en is sampled high.
- Data is readable starting from the request accepted on the next edge.

## Test plan
- Reset then fetch 0x0, 0x4, 0x3C with DEPTH=16, LATENCY=1:
  - req_ready=1 throughout.
  - Three responses on consecutive cycles, data 0, err 0.
- Load and sequential fetch:
  - Load 0x00000000@0x0, 0x20080006@0x4, 0x2009000D@0x8, 0x01095020@0xC, 0x010A4020@0x10.
  - Fetch 0x0..0x10 back-to-back.
  - Exact words returned in order, one per cycle, after LATENCY cycles (repeat with LATENCY=1,2,3).
- Backpressure with LATENCY=2:
  - Hold rsp_ready=0 for 3 cycles while req_valid=1.
  - req_ready=0 while the output is stalled, and rsp_data is stable.
  - After release, there are no lost or duplicated responses and order is preserved.
- Illegal fetches:
  - 0x6 (misaligned) and 0x40 (index 16 ≥ DEPTH): rsp_err=1, rsp_data=0.
  - A load to 0x40 leaves all 16 words unchanged.
- Same-edge load and fetch:
  - Index 3 holds 0x01095020.
  - On one edge, load 0xDEADBEEF and fetch 0xC. The response is 0x01095020.
  - The next fetch of 0xC returns 0xDEADBEEF.
- Reset asserted with 2 fetches in flight (LATENCY=3):
  - rsp_valid drops to 0 immediately, and no response appears after release.
  - A fetch of 0x4 after release returns 0.
